fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL declare parameter RESET_PC, default 32'h01000000, giving the first fetch address after reset.
REQ-002 SHALL have one clock and an asynchronous, active-high reset. Clock and reset ports come first, as follows.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- stall  input  1  hold the fetch PC and the F/D outputs
- PCSel  input  1  redirect request from execute
- alu_x  input  32  redirect target from execute
- imem_req  output  1  instruction read request
- imem_addr  output  32  request address
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- PC_d  output  32  PC of the instruction sent to decode
- inst_d  output  32  instruction sent to decode
- valid_d  output  1  PC_d/inst_d hold a real instruction
- fetch_count  output  32  instructions delivered (see REQ-016)
- flush_count  output  32  responses discarded (see REQ-016)

Function
REQ-003 SHALL allow at most one outstanding imem request, with responses returned in order.
REQ-004 SHALL use FSM states REQ (imem_req=1, imem_addr=fetch PC), WAIT (request granted, awaiting imem_rvalid) and HOLD (response buffered while stalled).
REQ-005 SHALL move REQ->WAIT on imem_gnt. WAIT->REQ on imem_rvalid with stall=0. WAIT->HOLD on imem_rvalid with stall=1. HOLD->REQ in the first cycle with stall=0.
REQ-006 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-007 On a delivered response, SHALL register PC_d<=request PC, inst_d<=imem_rdata, valid_d<=1, and fetch PC<=request PC+4, with the add wrapping modulo 2^32.
REQ-008 In a cycle with no delivery and stall=0, SHALL register a bubble: PC_d=0, inst_d=32'h00000013, valid_d=0.
REQ-009 While stall=1, SHALL hold PC_d/inst_d/valid_d unchanged and buffer any arriving response in a one-entry holding register. Data SHALL NOT be lost.
REQ-010 On PCSel=1, SHALL take precedence over stall and all other events in the same cycle:
- fetch PC<=alu_x
- F/D outputs<=bubble on the next edge
- FSM<=REQ
- any HOLD entry discarded
REQ-011 If PCSel=1 while in WAIT, the pending response SHALL be marked stale and dropped on arrival without reaching decode. The new request SHALL be issued only after that response arrives.
REQ-012 PCSel=1 in the same cycle as imem_rvalid SHALL drop that response.
REQ-013 Back-to-back PCSel pulses SHALL each restart fetch, with the last target winning.
REQ-014 Minimum latency with a zero-wait memory (gnt in REQ, rvalid the next cycle) SHALL be 2 cycles from request to valid_d=1, giving a throughput of 1 instruction every 2 cycles.

Reset
REQ-015 While reset=1, SHALL asynchronously force:
- FSM=REQ, fetch PC=RESET_PC, stale flag=0, holding register empty
- PC_d=0, inst_d=32'h13, valid_d=0
- imem_req=0; imem_req SHALL be 1 from the first clk edge after reset falls
- fetch_count=0, flush_count=0
Reset asserted mid-transaction SHALL abandon it, and a late imem_rvalid after reset SHALL be ignored.

Configuration
REQ-016 Macro FETCH_PERF_CNT_EN:
- Defined: fetch_count increments on each valid_d 0/1 load per REQ-007. flush_count increments on each response dropped per REQ-011/REQ-012 and on each discarded HOLD entry. Both wrap at 2^32.
- Undefined: both ports are constant 0 and no counter flops exist.

Verification
REQ-017 Reset release, zero-wait memory returning rdata=addr ^ 32'hFFFF0000. Required: PC_d sequence 0x01000000, 0x01000004, 0x01000008, with valid_d=1 every 2nd cycle and inst_d matching.
REQ-018 imem_gnt withheld 3 cycles. Required: imem_addr=0x01000000 held stable 4 cycles, then normal delivery.
REQ-019 stall=1 for 4 cycles while a response arrives. Required: outputs frozen during the stall, and the buffered instruction appears on the first unstalled edge, not duplicated.
REQ-020 PCSel=1, alu_x=0x01000100 while in WAIT, with the response arriving 2 cycles later. Required: stale response dropped, next valid PC_d=0x01000100, flush_count=1 with FETCH_PERF_CNT_EN.
REQ-021 PCSel=1 and stall=1 in the same cycle. Required: redirect wins, bubble emitted, next fetch at alu_x.
REQ-022 Redirect to 0xFFFFFFFC. Required: subsequent fetch address 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, stall buffering, and redirects.
// Define FETCH_PERF_CNT_EN to build the fetch/flush performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h01000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [31:0] alu_x,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_d,
  output logic [31:0] inst_d,
  output logic        valid_d,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] hold_inst;
  logic        stale;
  logic        deliver;

  // imem handshake: a request is accepted in a cycle where imem_req and imem_gnt are both 1;
  // imem_addr stays fixed until then. Exactly one imem_rvalid follows each accepted request.
  assign imem_addr = fetch_pc;

  // fetch_pc is the address of the in-flight (or held) instruction until it is delivered.
  assign deliver = !PCSel && !stall &&
                   ((state == S_WAIT && imem_rvalid && !stale) || state == S_HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      stale     <= 1'b0;
      hold_inst <= NOP;
      imem_req  <= 1'b0;
      PC_d      <= '0;
      inst_d    <= NOP;
      valid_d   <= 1'b0;
    end else begin
      if (PCSel || !stall) begin
        if (deliver) begin
          PC_d    <= fetch_pc;
          inst_d  <= (state == S_HOLD) ? hold_inst : imem_rdata;
          valid_d <= 1'b1;
        end else begin
          PC_d    <= '0;
          inst_d  <= NOP;
          valid_d <= 1'b0;
        end
      end

      if (PCSel) fetch_pc <= alu_x;
      else if (deliver) fetch_pc <= fetch_pc + 32'd4;

      // A redirect drops imem_req for one cycle so the address never changes under a pending request.
      case (state)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            stale    <= PCSel;
          end else begin
            imem_req <= !PCSel;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (stale || PCSel || !stall) begin
              state    <= S_REQ;
              imem_req <= !PCSel;
              stale    <= 1'b0;
            end else begin
              state     <= S_HOLD;
              hold_inst <= imem_rdata;
            end
          end else if (PCSel) begin
            stale <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSel || !stall) begin
            state    <= S_REQ;
            imem_req <= !PCSel;
          end
        end
        default: begin
          state    <= S_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        dropped;
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  assign dropped = PCSel ? (state == S_HOLD || (state == S_WAIT && imem_rvalid))
                         : (state == S_WAIT && imem_rvalid && stale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (dropped) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against an in-order PC-stream model
// and a memory model returning rdata = addr ^ 32'hFFFF0000.
module tb_fetch_unit;

  localparam logic [31:0] MASK = 32'hFFFF0000;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] RPC  = 32'h01000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        PCSel;
  logic [31:0] alu_x;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_d;
  logic [31:0] inst_d;
  logic        valid_d;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PCSel       (PCSel),
    .alu_x       (alu_x),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PC_d        (PC_d),
    .inst_d      (inst_d),
    .valid_d     (valid_d),
    .fetch_count (fetch_count),
    .flush_count (flush_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: the next PC decode must see, plus delivery/response accounting
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          delivered;
  int          accepted;

  // memory model
  logic        mem_pend;
  logic        mem_real;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_cfg;
  int          gnt_hold;
  bit          rand_mem;

  logic        last_req;
  logic [31:0] last_addr;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  logic        prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Checks the outputs produced by the edge just taken, using the inputs held before it.
  task automatic check_edge();
    if (imem_rvalid && mem_real) accepted++;
    if (PCSel) begin
      chk("redir_valid0", 32'(valid_d), 32'd0);
      chk("redir_pc0", PC_d, 32'd0);
      chk("redir_nop", inst_d, NOP);
      exp_next = alu_x;
    end else if (stall) begin
      chk("stall_pc", PC_d, prev_pc);
      chk("stall_inst", inst_d, prev_inst);
      chk("stall_valid", 32'(valid_d), 32'(prev_valid));
    end else if (valid_d) begin
      chk("model_pc", PC_d, exp_next);
      chk("model_inst", inst_d, exp_next ^ MASK);
      if (exp_q.size() != 0) chk("dir_pc", PC_d, exp_q.pop_front());
      exp_next = exp_next + 32'd4;
      delivered++;
    end else begin
      chk("bubble_pc", PC_d, 32'd0);
      chk("bubble_inst", inst_d, NOP);
    end
    if (last_req && !imem_gnt && !PCSel && imem_req)
      chk("addr_stable", imem_addr, last_addr);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, 32'(delivered));
    if (!stall) chk("flush_count", flush_count, 32'(accepted - delivered));
`else
    chk("fetch_count_off", fetch_count, 32'd0);
    chk("flush_count_off", flush_count, 32'd0);
`endif
  endtask

  task automatic mem_update();
    if (imem_rvalid) mem_pend = 1'b0;
    if (imem_gnt && last_req && !reset) begin
      mem_pend = 1'b1;
      mem_real = 1'b1;
      mem_addr = last_addr;
      mem_lat  = rand_mem ? int'($urandom_range(0, 2)) : lat_cfg;
    end
    if (!reset && mem_pend && mem_real) chk("one_outstanding", 32'(imem_req), 32'd0);
  endtask

  task automatic mem_drive();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      if (mem_lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr ^ MASK;
      end else begin
        mem_lat--;
      end
    end else if (imem_req && !reset) begin
      if (gnt_hold > 0) gnt_hold--;
      else begin
        imem_gnt = 1'b1;
        if (rand_mem) gnt_hold = int'($urandom_range(0, 2));
      end
    end
  endtask

  // driver: one clock, sampled 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!reset) check_edge();
    mem_update();
    mem_drive();
    last_req   = imem_req;
    last_addr  = imem_addr;
    prev_pc    = PC_d;
    prev_inst  = inst_d;
    prev_valid = valid_d;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (valid_d) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic model_reset();
    mem_real  = 1'b0;
    exp_next  = RPC;
    delivered = 0;
    accepted  = 0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; PCSel = 1'b0; alu_x = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_pend = 1'b0; mem_real = 1'b0; mem_addr = '0; mem_lat = 0;
    lat_cfg = 0; gnt_hold = 0; rand_mem = 1'b0; last_req = 1'b0; last_addr = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_pc", PC_d, 32'd0);
    chk("rst_inst", inst_d, NOP);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_fetch_cnt", fetch_count, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
    reset = 1'b0;
    prev_pc = PC_d; prev_inst = inst_d; prev_valid = valid_d;
    #3;
    chk("req_low_before_edge", 32'(imem_req), 32'd0);

    // zero-wait memory: one instruction every two cycles
    cycle();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    exp_q.push_back(RPC);
    exp_q.push_back(RPC + 32'd4);
    exp_q.push_back(RPC + 32'd8);
    cycle();
    chk("lat_valid0", 32'(valid_d), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("seq_valid", 32'(valid_d), (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // grant withheld for three cycles
    gnt_hold = 3;
    cycle();
    chk("pre_gnt_pc", PC_d, RPC + 32'h0C);
    for (int k = 0; k < 4; k++) begin
      chk("gnt_wait_req", 32'(imem_req), 32'd1);
      chk("gnt_wait_addr", imem_addr, RPC + 32'h10);
      chk("gnt_wait_gnt", 32'(imem_gnt), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) cycle();
    end
    exp_q.push_back(RPC + 32'h10);
    cycle();
    cycle();
    chk("gnt_wait_deliver", 32'(valid_d), 32'd1);

    // stall for four cycles while the next response arrives
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("frozen_valid", 32'(valid_d), 32'd1);
      chk("frozen_pc", PC_d, RPC + 32'h10);
    end
    stall = 1'b0;
    exp_q.push_back(RPC + 32'h14);
    cycle();
    chk("held_deliver", 32'(valid_d), 32'd1);
    cycle();
    chk("held_no_dup", 32'(valid_d), 32'd0);

    // redirect while waiting, response two cycles later
    lat_cfg = 2;
    cycle();
    cycle();
    PCSel = 1'b1; alu_x = 32'h01000100;
    cycle();
    PCSel = 1'b0; lat_cfg = 0;
    cycle();
    chk("stale_no_req", 32'(imem_req), 32'd0);
    chk("stale_valid0", 32'(valid_d), 32'd0);
    cycle();
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h01000100);
`ifdef FETCH_PERF_CNT_EN
    chk("stale_flush", flush_count, 32'd1);
`endif
    exp_q.push_back(32'h01000100);
    wait_valid("redir_deliver", 8);

    // redirect and stall together
    PCSel = 1'b1; stall = 1'b1; alu_x = 32'h01000200;
    cycle();
    PCSel = 1'b0; stall = 1'b0;
    cycle();
    chk("ps_req", 32'(imem_req), 32'd1);
    chk("ps_addr", imem_addr, 32'h01000200);
    exp_q.push_back(32'h01000200);
    wait_valid("ps_deliver", 8);

    // redirect to the top of the address space
    PCSel = 1'b1; alu_x = 32'hFFFFFFFC;
    cycle();
    PCSel = 1'b0;
    exp_q.push_back(32'hFFFFFFFC);
    wait_valid("wrap_deliver", 8);
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_addr", imem_addr, 32'd0);
    exp_q.push_back(32'd0);
    wait_valid("wrap_next", 8);

    // back-to-back redirects: last target wins
    PCSel = 1'b1; alu_x = 32'h01000300;
    cycle();
    alu_x = 32'h01000400;
    cycle();
    PCSel = 1'b0;
    exp_q.push_back(32'h01000400);
    wait_valid("b2b_deliver", 10);

    // reset in the middle of a transaction; the late response must be ignored
    lat_cfg = 2;
    wait_req("mid_req", 8);
    cycle();
    #1 reset = 1'b1;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(valid_d), 32'd0);
    chk("async_pc", PC_d, 32'd0);
    chk("async_inst", inst_d, NOP);
    chk("async_addr", imem_addr, RPC);
    model_reset();
    lat_cfg = 0;
    cycle();
    reset = 1'b0;
    chk("rst2_fetch_cnt", fetch_count, 32'd0);
    chk("rst2_flush_cnt", flush_count, 32'd0);
    cycle();
    chk("rst2_req", 32'(imem_req), 32'd1);
    chk("rst2_addr", imem_addr, RPC);
    exp_q.push_back(RPC);
    wait_valid("rst2_deliver", 8);

    // random traffic
    rand_mem = 1'b1;
    for (int n = 0; n < 600; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      PCSel = ($urandom_range(0, 11) == 0);
      alu_x = $urandom & 32'hFFFFFFFC;
      cycle();
    end
    stall = 1'b0; PCSel = 1'b0;
    wait_valid("drain", 16);
    chk("dir_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
